// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan sequencer.
// Holds the FSM state encoding, the default slot timing, the digit count and
// the widths derived from it. Imported by the interface, the slot timer and
// the top level.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } seg7_state_t;

    localparam int SLOT_LEN_DEF  = 50000;
    localparam int BLANK_LEN_DEF = 1000;

    localparam int NUM_DIGITS = 8;
    localparam int SCAN_W     = $clog2(NUM_DIGITS);
    localparam int HEX_W      = 4 * NUM_DIGITS;

    localparam logic [SCAN_W-1:0] LAST_DIGIT = SCAN_W'(NUM_DIGITS - 1);

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Update handshake between the single display requester and the scan
// sequencer.
//   upd_req   : level request, held with data stable until upd_ack
//   upd_hexs  : new display word, nibble i belongs to digit i
//   upd_point : new decimal-point bits
//   upd_les   : new digit-enable bits
//   upd_ack   : one-cycle pulse, update taken into the shadow registers
// master = requester side, slave = sequencer side.
interface seg7_upd_if;
    import seg7_pkg::*;

    logic                  upd_req;
    logic [HEX_W-1:0]      upd_hexs;
    logic [NUM_DIGITS-1:0] upd_point;
    logic [NUM_DIGITS-1:0] upd_les;
    logic                  upd_ack;

    modport master (
        output upd_req,
        output upd_hexs,
        output upd_point,
        output upd_les,
        input  upd_ack
    );

    modport slave (
        input  upd_req,
        input  upd_hexs,
        input  upd_point,
        input  upd_les,
        output upd_ack
    );

endinterface

// File: rtl/seg7_slot_timer.sv
// Per-digit slot counter with terminal-count strobes.
//   clk, rst  : system clock, asynchronous active-high reset
//   run       : count while high; cleared to 0 while low
//   cnt       : position inside the current slot
//   blank_end : cnt is at the last blanked cycle (BLANK_LEN-1)
//   slot_end  : cnt is at the last cycle of the slot (SLOT_LEN-1)
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter  int SLOT_LEN  = SLOT_LEN_DEF,
    parameter  int BLANK_LEN = BLANK_LEN_DEF,
    localparam int CNT_W     = $clog2(SLOT_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic             blank_end,
    output logic             slot_end
);

    assign blank_end = (cnt == CNT_W'(BLANK_LEN - 1));
    assign slot_end  = (cnt == CNT_W'(SLOT_LEN - 1));

    // BLANK_LEN < SLOT_LEN, so slot_end can only be reached from SHOW and
    // wrapping the counter here always starts a fresh slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan sequencer for the 8-digit seven-segment display.
// Steps the digit index, blanks the anodes at the start of every slot to
// avoid ghosting, pulses frame_tick on each 7->0 wrap, and keeps shadow
// copies of the display data that only change at a frame boundary (or
// immediately while the display is off).
//   clk, rst   : system clock, asynchronous active-high reset
//   en         : scan enable; low blanks the display and freezes scan
//   upd        : update handshake (slave side)
//   scan       : current digit index
//   hexs       : shadow display word
//   point      : shadow decimal points
//   les        : shadow digit enables
//   blank      : 1 forces all anodes off
//   frame_tick : one-cycle pulse in the cycle after the 7->0 wrap edge
//
// state | meaning
// ------+--------------------------------------------------------
// OFF   | disabled; blanked, slot counter held at 0, scan frozen
// BLANK | first BLANK_LEN cycles of a slot, anodes forced off
// SHOW  | rest of the slot, current digit driven
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SLOT_LEN  = SLOT_LEN_DEF,
    parameter int BLANK_LEN = BLANK_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    seg7_upd_if.slave             upd,
    output logic [SCAN_W-1:0]     scan,
    output logic [HEX_W-1:0]      hexs,
    output logic [NUM_DIGITS-1:0] point,
    output logic [NUM_DIGITS-1:0] les,
    output logic                  blank,
    output logic                  frame_tick
);

    localparam int CNT_W = $clog2(SLOT_LEN);

    seg7_state_t state_q, state_d;

    logic [CNT_W-1:0] cnt;
    logic             blank_end;
    logic             slot_end;
    logic             run;

    logic [SCAN_W-1:0] scan_d;
    logic              wrap;
    logic              load;
    logic              blank_d;
    logic              ack_q;

    assign run = en && (state_q != ST_OFF);

    seg7_slot_timer #(
        .SLOT_LEN  (SLOT_LEN),
        .BLANK_LEN (BLANK_LEN)
    ) u_slot_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cnt       (cnt),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF:   state_d = ST_BLANK;
                ST_BLANK: if (blank_end) state_d = ST_SHOW;
                ST_SHOW:  if (slot_end)  state_d = ST_BLANK;
                default:  state_d = ST_OFF;
            endcase
        end
    end

    // The digit step is not gated by en: a slot that ends on the same edge
    // en falls still completes, so a 7->0 wrap (and its load) is never lost.
    always_comb begin
        scan_d  = scan;
        wrap    = 1'b0;
        if ((state_q == ST_SHOW) && slot_end) begin
            scan_d = scan + SCAN_W'(1);
            wrap   = (scan == LAST_DIGIT);
        end
        // ack_q blocks a second load of a request still held through its ack.
        load    = upd.upd_req && !ack_q && (wrap || (state_q == ST_OFF));
        blank_d = (state_d != ST_SHOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan       <= '0;
            blank      <= 1'b1;
            frame_tick <= 1'b0;
            ack_q      <= 1'b0;
            hexs       <= '0;
            point      <= '0;
            les        <= '0;
        end else begin
            scan       <= scan_d;
            blank      <= blank_d;
            frame_tick <= wrap;
            ack_q      <= load;
            if (load) begin
                hexs  <= upd.upd_hexs;
                point <= upd.upd_point;
                les   <= upd.upd_les;
            end
        end
    end

    assign upd.upd_ack = ack_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;
    import seg7_pkg::*;

    localparam int SL = 8;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  scan;
    logic [31:0] hexs;
    logic [7:0]  point;
    logic [7:0]  les;
    logic        blank;
    logic        frame_tick;

    seg7_upd_if upd ();

    seg7_scan_ctrl #(
        .SLOT_LEN  (SL),
        .BLANK_LEN (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .upd        (upd),
        .scan       (scan),
        .hexs       (hexs),
        .point      (point),
        .les        (les),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] h;
        logic [7:0]  p;
        logic [7:0]  l;
    } upd_t;

    upd_t sb_q[$];
    upd_t cur;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] h, input logic [7:0] p, input logic [7:0] l,
                           input bit expect_take);
        upd_t e;
        upd.upd_req   = 1'b1;
        upd.upd_hexs  = h;
        upd.upd_point = p;
        upd.upd_les   = l;
        e.h = h; e.p = p; e.l = l;
        if (expect_take) sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        upd.upd_req   = 1'b0;
        upd.upd_hexs  = '0;
        upd.upd_point = '0;
        upd.upd_les   = '0;
        cur = '0;
        repeat (2) tick();
        vectors++;
        if ({scan, hexs, point, les} !== 51'd0) begin
            miscompares++;
            $display("FAIL reset_data: scan=%0h hexs=%0h point=%0h les=%0h want all 0",
                     scan, hexs, point, les);
        end
        vectors++;
        if ({blank, frame_tick, upd.upd_ack} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_ctrl: blank/ft/ack=%b want 100",
                     {blank, frame_tick, upd.upd_ack});
        end
    endtask

    task automatic test_scan_timing();
        int ft_hits = 0;
        logic [2:0] es;
        logic       eb, ef;
        en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 1; c <= 140; c++) begin
            tick();
            es = 3'(((c - 1) / SL) % 8);
            eb = ((c - 1) % SL) < BL;
            ef = (c > 1) && (((c - 1) % (8 * SL)) == 0);
            if (frame_tick === 1'b1) ft_hits++;
            vectors++;
            if (scan !== es) begin
                miscompares++;
                $display("FAIL timing_scan c=%0d: got %0d want %0d", c, scan, es);
            end
            vectors++;
            if (blank !== eb) begin
                miscompares++;
                $display("FAIL timing_blank c=%0d: got %b want %b", c, blank, eb);
            end
            vectors++;
            if (frame_tick !== ef) begin
                miscompares++;
                $display("FAIL timing_frame_tick c=%0d: got %b want %b", c, frame_tick, ef);
            end
        end
        vectors++;
        if (ft_hits != 2) begin
            miscompares++;
            $display("FAIL timing_ft_count: got %0d want 2", ft_hits);
        end
    endtask

    task automatic test_en_pause();
        int  i;
        logic eb;
        logic [2:0] es;
        en = 1'b1;
        for (i = 0; i < 200 && !(scan == 3'd5 && blank == 1'b0); i++) tick();
        vectors++;
        if (i >= 200) begin
            miscompares++;
            $display("FAIL pause_wait: scan=%0d blank=%b want scan 5 shown", scan, blank);
            return;
        end
        tick();
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            vectors++;
            if ({scan, blank, frame_tick} !== {3'd5, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL pause_hold k=%0d: scan=%0d blank=%b ft=%b want 5 1 0",
                         k, scan, blank, frame_tick);
            end
        end
        en = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            eb = (c <= BL) || (c == SL + 1);
            es = (c <= SL) ? 3'd5 : 3'd6;
            vectors++;
            if ({scan, blank} !== {es, eb}) begin
                miscompares++;
                $display("FAIL resume c=%0d: scan=%0d blank=%b want %0d %b",
                         c, scan, blank, es, eb);
            end
        end
    endtask

    task automatic test_update_scan();
        int   i;
        int   acks = 0;
        upd_t e;
        en = 1'b1;
        for (i = 0; i < 200 && scan != 3'd3; i++) tick();
        vectors++;
        if (i >= 200) begin
            miscompares++;
            $display("FAIL upd_scan_wait: scan=%0d want 3", scan);
            return;
        end
        request(32'h89ABCDEF, 8'h5A, 8'h3C, 1'b1);
        for (int k = 0; k < 100; k++) begin
            tick();
            if (upd.upd_ack === 1'b1) begin
                acks++;
                upd.upd_req = 1'b0;
                vectors++;
                if ({frame_tick, scan} !== {1'b1, 3'd0}) begin
                    miscompares++;
                    $display("FAIL upd_scan_ack_align: ft=%b scan=%0d want 1 0",
                             frame_tick, scan);
                end
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL upd_scan_sb: ack with empty scoreboard, want pending entry");
                end else begin
                    e = sb_q.pop_front();
                    cur = e;
                    if ({hexs, point, les} !== e) begin
                        miscompares++;
                        $display("FAIL upd_scan_data: got %h %h %h want %h %h %h",
                                 hexs, point, les, e.h, e.p, e.l);
                    end
                end
            end else if (acks == 0) begin
                vectors++;
                if (hexs !== cur.h) begin
                    miscompares++;
                    $display("FAIL upd_scan_early k=%0d: hexs=%h want %h", k, hexs, cur.h);
                end
            end
        end
        vectors++;
        if (acks != 1) begin
            miscompares++;
            $display("FAIL upd_scan_ack_count: got %0d want 1", acks);
        end
        upd.upd_req = 1'b0;
    endtask

    task automatic test_update_off();
        upd_t e;
        en = 1'b0;
        repeat (2) tick();
        request(32'h12345678, 8'h81, 8'hF0, 1'b1);
        tick();
        vectors++;
        if (upd.upd_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL off_ack: got %b want 1", upd.upd_ack);
        end
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL off_sb: empty scoreboard, want pending entry");
        end else begin
            e = sb_q.pop_front();
            cur = e;
            if ({hexs, point, les} !== e) begin
                miscompares++;
                $display("FAIL off_data: got %h %h %h want %h %h %h",
                         hexs, point, les, e.h, e.p, e.l);
            end
        end
        tick();
        vectors++;
        if (upd.upd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL off_no_double_ack: got %b want 0", upd.upd_ack);
        end
        upd.upd_req = 1'b0;
        tick();
        vectors++;
        if ({upd.upd_ack, les} !== {1'b0, 8'hF0}) begin
            miscompares++;
            $display("FAIL off_settle: ack=%b les=%h want 0 f0", upd.upd_ack, les);
        end
    endtask

    task automatic test_wrap_request();
        int   i;
        logic [2:0] prev;
        upd_t e;
        en = 1'b1;
        prev = scan;
        for (i = 0; i < 200; i++) begin
            tick();
            if (scan == 3'd7 && prev != 3'd7) break;
            prev = scan;
        end
        vectors++;
        if (i >= 200) begin
            miscompares++;
            $display("FAIL wrap_wait: scan=%0d want entry into 7", scan);
            return;
        end
        repeat (SL - 1) tick();
        vectors++;
        if ({scan, upd.upd_ack, frame_tick, blank} !== {3'd7, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_pre: scan=%0d ack=%b ft=%b blank=%b want 7 0 0 0",
                     scan, upd.upd_ack, frame_tick, blank);
        end
        request(32'hCAFEF00D, 8'h0F, 8'hA5, 1'b1);
        tick();
        vectors++;
        if ({upd.upd_ack, frame_tick, scan} !== {1'b1, 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL wrap_ack: ack=%b ft=%b scan=%0d want 1 1 0",
                     upd.upd_ack, frame_tick, scan);
        end
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL wrap_sb: empty scoreboard, want pending entry");
        end else begin
            e = sb_q.pop_front();
            cur = e;
            if ({hexs, point, les} !== e) begin
                miscompares++;
                $display("FAIL wrap_data: got %h %h %h want %h %h %h",
                         hexs, point, les, e.h, e.p, e.l);
            end
        end
        upd.upd_req = 1'b0;
        tick();
        vectors++;
        if (upd.upd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_ack_once: got %b want 0", upd.upd_ack);
        end
    endtask

    task automatic test_reset_mid();
        int   i;
        upd_t e;
        en = 1'b1;
        for (i = 0; i < 200 && blank != 1'b0; i++) tick();
        vectors++;
        if (i >= 200) begin
            miscompares++;
            $display("FAIL rstmid_wait: blank=%b want 0", blank);
            return;
        end
        tick();
        request(32'hDEADBEEF, 8'hFF, 8'hFF, 1'b0);
        tick();
        #3 rst = 1'b1;
        #1;
        vectors++;
        if ({scan, hexs, point, les} !== 51'd0) begin
            miscompares++;
            $display("FAIL rstmid_data: scan=%0h hexs=%0h point=%0h les=%0h want all 0",
                     scan, hexs, point, les);
        end
        vectors++;
        if ({blank, frame_tick, upd.upd_ack} !== 3'b100) begin
            miscompares++;
            $display("FAIL rstmid_ctrl: blank/ft/ack=%b want 100",
                     {blank, frame_tick, upd.upd_ack});
        end
        cur = '0;
        repeat (2) tick();
        vectors++;
        if (upd.upd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_no_ack: got %b want 0", upd.upd_ack);
        end
        upd.upd_req = 1'b0;
        en = 1'b0;
        tick();
        rst = 1'b0;
        request(32'h0BADC0DE, 8'h11, 8'h22, 1'b1);
        tick();
        vectors++;
        if (upd.upd_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_reack: got %b want 1", upd.upd_ack);
        end
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL rstmid_sb: empty scoreboard, want pending entry");
        end else begin
            e = sb_q.pop_front();
            cur = e;
            if ({hexs, point, les} !== e) begin
                miscompares++;
                $display("FAIL rstmid_data2: got %h %h %h want %h %h %h",
                         hexs, point, les, e.h, e.p, e.l);
            end
        end
        upd.upd_req = 1'b0;
        tick();
        vectors++;
        if (upd.upd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_ack_once: got %b want 0", upd.upd_ack);
        end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_en_pause();
        test_update_scan();
        test_update_off();
        test_wrap_request();
        test_reset_mid();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
